// File: rtl/trace_capture_pkg.sv
// rtl/trace_capture_pkg.sv - shared types and constants for the trace capture controller
//
// Holds the controller state encoding, the default memory/readout geometry,
// the entry-count width and the readout index that selects the trigger
// timestamp (only meaningful when TRACE_CAPTURE_TSTAMP_EN is defined).
package trace_capture_pkg;

    localparam int DATA_W      = 1260;  // probe / memory word width
    localparam int ADDR_W      = 9;     // capture memory address width (512 deep)
    localparam int RD_W        = 32;    // host readout word width
    localparam int RD_WORDS    = 40;    // readout words covering one entry (last one partial)
    localparam int CNT_W       = 10;    // width of cap_count, holds 0..512
    localparam int WORD_IDX_W  = 6;     // width of the rd_word index
    localparam int TSTAMP_WORD = 63;    // rd_word value returning the trigger timestamp

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_POST = 3'd2,
        S_DONE = 3'd3,
        S_RD1  = 3'd4,
        S_RD2  = 3'd5
    } state_e;

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// rtl/trace_capture_ctrl_if.sv - capture memory port between trace_capture_ctrl and the 512 x DATA_W memory
//
// Signals:
//   mem_en   enable, one access per cycle
//   mem_we   write enable (read when low and mem_en high)
//   mem_addr word address
//   mem_din  write data
//   mem_dout read data, valid the cycle after a read access
// Modports: master = capture controller, slave = memory.
interface trace_capture_ctrl_if #(
    parameter int DATA_W = trace_capture_pkg::DATA_W,
    parameter int ADDR_W = trace_capture_pkg::ADDR_W
) ();

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );

endinterface

// File: rtl/trace_word_mux.sv
// rtl/trace_word_mux.sv - registered DATA_W-to-RD_W slice select for host readout
//
// Ports:
//   clk, rstn   clock, async active-low reset
//   load        capture a new result this cycle
//   word        readout word index within the entry
//   din         memory entry being read
//   ovr_en      load ovr_data instead of a slice of din
//   ovr_data    alternate result (trigger timestamp)
//   dout        registered result, holds between loads
// Words past the end of din read as zero; the last partial word is zero-padded.
module trace_word_mux #(
    parameter int DATA_W = trace_capture_pkg::DATA_W,
    parameter int RD_W   = trace_capture_pkg::RD_W
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    load,
    input  logic [trace_capture_pkg::WORD_IDX_W-1:0] word,
    input  logic [DATA_W-1:0]                       din,
    input  logic                                    ovr_en,
    input  logic [RD_W-1:0]                         ovr_data,
    output logic [RD_W-1:0]                         dout
);

    import trace_capture_pkg::*;

    // Zero-extending din to a whole number of readout words turns the
    // partial last word into an ordinary slice.
    localparam int PAD_W = RD_WORDS * RD_W;
    localparam int IDX_W = $clog2(PAD_W);

    logic [PAD_W-1:0] padded;
    logic [IDX_W-1:0] bit_lo;
    logic [RD_W-1:0]  slice;

    assign padded = PAD_W'(din);
    assign bit_lo = IDX_W'(word) * IDX_W'(RD_W);

    always_comb begin
        slice = '0;
        if (int'(word) < RD_WORDS) begin
            slice = padded[bit_lo +: RD_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= '0;
        end else if (load) begin
            dout <= ovr_en ? ovr_data : slice;
        end
    end

endmodule

// File: rtl/trace_capture_ctrl.sv
// rtl/trace_capture_ctrl.sv - circular trace capture into a 512-deep memory with frozen-buffer host readout
//
// Optional feature macro: TRACE_CAPTURE_TSTAMP_EN (free-running cycle counter,
// latched on the trigger, returned on rd_word 63 without a memory access).
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   arm                  pulse, starts a new capture session
//   trig_in              trigger, level-sampled while armed
//   sample_valid, sample probe qualifier and vector
//   mem                  capture memory port (master side)
//   busy                 capture session in progress (PRE or POST)
//   done                 capture frozen
//   wrapped              write pointer wrapped this session
//   cap_count            valid entries, 0..512
//   trig_addr            physical address of the trigger sample
//   rd_req/rd_entry/rd_word  host read request, logical entry (0 = oldest), word index
//   rd_ack/rd_data       one-cycle completion pulse, result held until the next ack
module trace_capture_ctrl #(
    parameter int DATA_W    = trace_capture_pkg::DATA_W,
    parameter int ADDR_W    = trace_capture_pkg::ADDR_W,
    parameter int POST_TRIG = 256,
    parameter int RD_W      = trace_capture_pkg::RD_W
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     arm,
    input  logic                                     trig_in,
    input  logic                                     sample_valid,
    input  logic [DATA_W-1:0]                        sample,
    trace_capture_ctrl_if.master                     mem,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     wrapped,
    output logic [trace_capture_pkg::CNT_W-1:0]      cap_count,
    output logic [ADDR_W-1:0]                        trig_addr,
    input  logic                                     rd_req,
    input  logic [ADDR_W-1:0]                        rd_entry,
    input  logic [trace_capture_pkg::WORD_IDX_W-1:0] rd_word,
    output logic                                     rd_ack,
    output logic [RD_W-1:0]                          rd_data
);

    import trace_capture_pkg::*;

    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_PRE  = S_PRE;
    localparam logic [2:0] ST_POST = S_POST;
    localparam logic [2:0] ST_DONE = S_DONE;
    localparam logic [2:0] ST_RD1  = S_RD1;
    localparam logic [2:0] ST_RD2  = S_RD2;

    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_TRIG);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(1 << ADDR_W);

    logic [2:0]            state;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     oldest;
    logic [CNT_W-1:0]      post_cnt;
    logic [CNT_W-1:0]      post_nxt;
    logic [WORD_IDX_W-1:0] rd_word_q;

    logic capturing;
    logic ready_state;
    logic start;
    logic cap_we;
    logic trig_ok;
    logic rd_accept;
    logic rd_mem;
    logic ts_sel;
    logic [RD_W-1:0] ts_val;

    assign capturing   = (state == ST_PRE) || (state == ST_POST);
    assign ready_state = (state == ST_IDLE) || (state == ST_DONE);

    // arm restarts from any state except an in-flight read.
    assign start     = arm && (capturing || ready_state);
    // The arm cycle only sets up the session; its sample and trigger are dropped.
    assign cap_we    = capturing && sample_valid && !arm;
    assign trig_ok   = (state == ST_PRE) && trig_in && !arm;
    assign rd_accept = ready_state && rd_req && !arm;

    assign post_nxt  = post_cnt + 1'b1;
    assign oldest    = wrapped ? wr_ptr : '0;

`ifdef TRACE_CAPTURE_TSTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_trig;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt  <= '0;
            ts_trig <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (trig_ok) begin
                ts_trig <= ts_cnt;
            end
        end
    end

    assign ts_sel = (rd_word_q == WORD_IDX_W'(TSTAMP_WORD));
    assign ts_val = RD_W'(ts_trig);
`else
    assign ts_sel = 1'b0;
    assign ts_val = '0;
`endif

    // The timestamp word is served from the latch, so the memory stays idle.
    assign rd_mem = (state == ST_RD1) && !ts_sel;

    assign mem.mem_en   = cap_we || rd_mem;
    assign mem.mem_we   = cap_we;
    assign mem.mem_addr = rd_mem ? rd_addr : (cap_we ? wr_ptr : '0);
    assign mem.mem_din  = cap_we ? sample : '0;

    assign busy      = capturing;
    assign cap_count = wrapped ? FULL_CNT : CNT_W'(wr_ptr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            wrapped   <= 1'b0;
            post_cnt  <= '0;
            done      <= 1'b0;
            trig_addr <= '0;
            rd_addr   <= '0;
            rd_word_q <= '0;
            rd_ack    <= 1'b0;
        end else begin
            rd_ack <= (state == ST_RD2);
            if (start) begin
                state    <= ST_PRE;
                wr_ptr   <= '0;
                wrapped  <= 1'b0;
                post_cnt <= '0;
                done     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (rd_accept) begin
                            rd_addr   <= oldest + rd_entry;
                            rd_word_q <= rd_word;
                            state     <= ST_RD1;
                        end
                    end
                    ST_PRE, ST_POST: begin
                        if (trig_ok) begin
                            trig_addr <= wr_ptr;
                            state     <= ST_POST;
                        end
                        if (sample_valid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (wr_ptr == '1) begin
                                wrapped <= 1'b1;
                            end
                            // The trigger-cycle sample already counts as post sample 1.
                            if ((state == ST_POST) || trig_ok) begin
                                post_cnt <= post_nxt;
                                if (post_nxt == POST_LAST) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RD1: begin
                        state <= ST_RD2;
                    end
                    ST_RD2: begin
                        state <= done ? ST_DONE : ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    trace_word_mux #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_word_mux (
        .clk      (clk),
        .rstn     (rstn),
        .load     (state == ST_RD2),
        .word     (rd_word_q),
        .din      (mem.mem_dout),
        .ovr_en   (ts_sel),
        .ovr_data (ts_val),
        .dout     (rd_data)
    );

endmodule
